seq_det_sched: RTL and testbench

Scheduler that shares one serial "101" overlapping Moore sequence detector between two parallel-word requesters. It arbitrates round-robin between the two input channels and serializes the granted word MSB-first into the detector, one bit per clock. It counts detector matches over the word and returns a per-word result with a valid/ready handshake. It sits between word-oriented producers and the bit-serial detection datapath.

---
 rtl/seq_det_sched.sv | 157 +++++++++++++++
 tb/tb_seq_det_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_sched.sv
// -----------------------------------------------------------------------------
// seq_det_sched
//
// Shares one bit-serial "101" overlapping Moore detector between two
// word-oriented requesters. In IDLE a round-robin arbiter accepts one word;
// the word is then shifted MSB-first into the detector for WORD_W cycles while
// matches are counted, and the per-word result is offered on a valid/ready
// port until consumed.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. A producer may drop valid while not accepted; the result side holds
// res_ch/res_count/res_hit stable while res_valid is high and res_ready is low.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in0_valid/data/ready  channel 0 word request
//   in1_valid/data/ready  channel 1 word request
//   res_valid/ready       result handshake
//   res_ch                channel the result belongs to
//   res_count             matches in the word (saturating)
//   res_hit               res_count != 0
//   busy                  control FSM not in IDLE
// -----------------------------------------------------------------------------
module seq_det_sched #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    input  logic [WORD_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [WORD_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_ch,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_hit,
    output logic              busy
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_REPORT = 2'd2
    } ctrl_t;

    typedef enum logic [2:0] {
        D_A = 3'd0,
        D_B = 3'd1,
        D_C = 3'd2,
        D_D = 3'd3,
        D_E = 3'd4
    } det_t;

    ctrl_t              r_state;
    det_t               r_det;
    logic [WORD_W-1:0]  r_shift;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_count;
    logic               r_res_ch;
    logic               r_last_grant;

    logic               w_grant;
    logic               w_idle;
    logic               w_accept;
    logic               w_bit;
    det_t               w_det_next;

    // Detector next-state; D is the "101 seen" state, illegal codes recover to A.
    function automatic det_t det_step(input det_t s, input logic x);
        case (s)
            D_A:     det_step = x ? D_B : D_A;
            D_B:     det_step = x ? D_B : D_C;
            D_C:     det_step = x ? D_D : D_A;
            D_D:     det_step = x ? D_B : D_E;
            D_E:     det_step = x ? D_D : D_A;
            default: det_step = D_A;
        endcase
    endfunction

    // Single requester wins outright; on a tie the channel not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (in0_valid && in1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = in1_valid;
        end
    end

    assign w_idle     = (r_state == S_IDLE);
    assign in0_ready  = w_idle & ~w_grant & in0_valid;
    assign in1_ready  = w_idle &  w_grant & in1_valid;
    assign w_accept   = in0_ready | in1_ready;
    assign w_bit      = r_shift[WORD_W-1];
    assign w_det_next = det_step(r_det, w_bit);

    assign res_valid  = (r_state == S_REPORT);
    assign busy       = ~w_idle;
    assign res_ch     = r_res_ch;
    assign res_count  = r_count;
    assign res_hit    = (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_det        <= D_A;
            r_shift      <= '0;
            r_idx        <= '0;
            r_count      <= '0;
            r_res_ch     <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift      <= w_grant ? in1_data : in0_data;
                        r_res_ch     <= w_grant;
                        r_count      <= '0;
                        r_idx        <= '0;
                        // Each word starts from a clean detector history.
                        r_det        <= D_A;
                        r_last_grant <= w_grant;
                        r_state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shift <= {r_shift[WORD_W-2:0], 1'b0};
                    r_det   <= w_det_next;
                    // Count on entry to D so a match on the final bit is included.
                    if ((w_det_next == D_D) && (r_count != '1)) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// -----------------------------------------------------------------------------
// tb_seq_det_sched
//
// Drives both word channels and the result port; a negedge monitor models the
// arbiter, computes expected match counts by scanning each accepted word for
// overlapping "101" patterns, and compares against the result port through an
// expected queue. A second instance with CNT_W=1 covers counter saturation.
// -----------------------------------------------------------------------------
module tb_seq_det_sched;

    localparam int W = 8;
    localparam int C = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in0_valid, in1_valid;
    logic [W-1:0]  in0_data, in1_data;
    logic          in0_ready, in1_ready;
    logic          res_valid, res_ready, res_ch, res_hit, busy;
    logic [C-1:0]  res_count;

    logic          s_in0_valid, s_in1_valid;
    logic [W-1:0]  s_in0_data, s_in1_data;
    logic          s_in0_ready, s_in1_ready;
    logic          s_res_valid, s_res_ready, s_res_ch, s_res_hit, s_busy;
    logic [0:0]    s_res_count;

    seq_det_sched #(.WORD_W(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
        .res_count(res_count), .res_hit(res_hit), .busy(busy)
    );

    seq_det_sched #(.WORD_W(W), .CNT_W(1)) dut_s (
        .clk(clk), .rst(rst),
        .in0_valid(s_in0_valid), .in0_data(s_in0_data), .in0_ready(s_in0_ready),
        .in1_valid(s_in1_valid), .in1_data(s_in1_data), .in1_ready(s_in1_ready),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_ch(s_res_ch),
        .res_count(s_res_count), .res_hit(s_res_hit), .busy(s_busy)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: overlapping "101" occurrences in the MSB-first bit string.
    function automatic int ref_count(input logic [W-1:0] w, input int cnt_w);
        int n;
        int max_v;
        n = 0;
        for (int i = W - 1; i >= 2; i--) begin
            if (w[i] == 1'b1 && w[i-1] == 1'b0 && w[i-2] == 1'b1) n++;
        end
        max_v = (1 << cnt_w) - 1;
        return (n > max_v) ? max_v : n;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [C:0]   exp_q[$];
    int           acc_log[$];
    bit           outstanding = 0;
    bit           m_last = 1;
    int           cyc = 0;
    int           acc_cyc = 0;
    bit           prev_v = 0;
    bit           prev_r = 0;
    logic         sv_ch;
    logic [C-1:0] sv_count;
    logic         sv_hit;
    logic [1:0]   exp_r;
    int           g;
    logic         m_ch;
    logic [W-1:0] m_data;
    logic [C:0]   m_exp;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            outstanding = 0;
            m_last = 1;
            prev_v = 0;
            prev_r = 0;
        end else begin
            if (outstanding) begin
                exp_r = 2'b00;
            end else begin
                g = (in0_valid && in1_valid) ? int'(!m_last) : int'(in1_valid);
                exp_r = {in1_valid && (g == 1), in0_valid && (g == 0)};
            end
            check("ready_pattern", {in1_ready, in0_ready}, exp_r);

            if ((in0_valid && in0_ready) || (in1_valid && in1_ready)) begin
                m_ch   = in1_ready;
                m_data = m_ch ? in1_data : in0_data;
                exp_q.push_back({m_ch, C'(ref_count(m_data, C))});
                m_last = m_ch;
                outstanding = 1;
                acc_cyc = cyc;
                acc_log.push_back(int'(m_ch));
            end

            if (prev_v && !prev_r) begin
                check("res_valid_held", res_valid, 1);
                if (res_valid) begin
                    check("stall_res_ch", res_ch, sv_ch);
                    check("stall_res_count", res_count, sv_count);
                    check("stall_res_hit", res_hit, sv_hit);
                end
            end

            if (res_valid) begin
                if (!prev_v) check("latency", cyc - acc_cyc, W + 1);
                if (res_ready) begin
                    check("result_expected", exp_q.size(), 1);
                    if (exp_q.size() != 0) begin
                        m_exp = exp_q.pop_front();
                        check("res_ch", res_ch, m_exp[C]);
                        check("res_count", res_count, m_exp[C-1:0]);
                        check("res_hit", res_hit, int'(m_exp[C-1:0] != '0));
                    end
                    outstanding = 0;
                end
            end
            prev_v   = res_valid;
            prev_r   = res_ready;
            sv_ch    = res_ch;
            sv_count = res_count;
            sv_hit   = res_hit;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input bit ch, input logic [W-1:0] d);
        int n;
        n = 0;
        if (ch) begin in1_data = d; in1_valid = 1'b1; end
        else begin in0_data = d; in0_valid = 1'b1; end
        do begin
            @(negedge clk);
            n++;
        end while (!(ch ? in1_ready : in0_ready) && n < 200);
        check("accept_wait", ch ? in1_ready : in0_ready, 1);
        @(posedge clk);
        #1;
        if (ch) in1_valid = 1'b0;
        else in0_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (outstanding && n < 300);
        check("wait_done_timeout", outstanding, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int n;
    logic acc_ch;

    initial begin
        rst = 1'b1;
        in0_valid = 0; in1_valid = 0; in0_data = '0; in1_data = '0;
        res_ready = 1'b1;
        s_in0_valid = 0; s_in1_valid = 0; s_in0_data = '0; s_in1_data = '0;
        s_res_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_res_count", res_count, 0);
        check("rst_res_hit", res_hit, 0);
        check("rst_res_ch", res_ch, 0);
        check("rst_readies", {in1_ready, in0_ready}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed words
        send_word(1'b0, 8'b10101010); wait_done();
        send_word(1'b1, 8'hFF);       wait_done();
        send_word(1'b1, 8'b00000101); wait_done();

        // Both channels valid from reset: strict alternation starting at ch0
        in0_valid = 1'b1; in1_valid = 1'b1;
        in0_data = W'($urandom); in1_data = W'($urandom);
        do_reset(2);
        acc_log.delete();
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(in0_ready || in1_ready) && n < 200);
            check("tie_accept_wait", int'(in0_ready || in1_ready), 1);
            acc_ch = in1_ready;
            @(posedge clk);
            #1;
            if (acc_ch) in1_data = W'($urandom);
            else in0_data = W'($urandom);
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        wait_done();
        check("tie_accepts", acc_log.size(), 4);
        for (int k = 0; k < 4 && k < acc_log.size(); k++) begin
            check("tie_order", acc_log[k], k % 2);
        end

        // Result backpressure for 5 cycles
        res_ready = 1'b0;
        send_word(1'b1, 8'b01011010);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 50);
        check("bp_res_valid", res_valid, 1);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_busy", busy, 1);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_done();

        // Reset in the 4th SHIFT cycle
        send_word(1'b0, W'($urandom));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_res_valid", res_valid, 0);
        send_word(1'b0, 8'b01010000);
        wait_done();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            in0_valid = ($urandom_range(0, 3) != 0);
            in1_valid = ($urandom_range(0, 3) != 0);
            in0_data  = W'($urandom);
            in1_data  = W'($urandom);
            res_ready = ($urandom_range(0, 2) != 0);
        end
        in0_valid = 1'b0; in1_valid = 1'b0; res_ready = 1'b1;
        wait_done();

        // Saturating counter instance
        s_in0_data = 8'b10101010;
        s_in0_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_in0_ready && n < 50);
        check("sat_accept", s_in0_ready, 1);
        @(posedge clk);
        #1 s_in0_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_res_valid && n < 50);
        check("sat_latency", n, W + 1);
        check("sat_res_valid", s_res_valid, 1);
        check("sat_res_count", s_res_count, ref_count(8'b10101010, 1));
        check("sat_res_hit", s_res_hit, 1);
        check("sat_res_ch", s_res_ch, 0);
        @(posedge clk);
        @(negedge clk);
        check("sat_idle", s_busy, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
